// File: rtl/wb_pkg.sv
// Shared types, default sizes and width helpers for the writeback output packer.
package wb_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_PACK       = 4;
    localparam int DEFAULT_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH2 = 2'd1,
        DRAIN  = 2'd2
    } wb_state_e;

    // Lane count spans 0..PACK inclusive, hence the +1.
    function automatic int lane_cnt_w(input int pack);
        return $clog2(pack + 1);
    endfunction

    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module wb_sync_fifo
    import wb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic                       full,
    output logic [fifo_ptr_w(DEPTH):0] count
);
    localparam int PTR_W = fifo_ptr_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PTR_W + 1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    // NOTE: defaults first so every path assigns each _d signal; no latches.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments for all state so flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && full && !do_pop));
    end

endmodule

// File: rtl/wb_out_packer.sv
// Packs the writeback result stream into PACK-lane beats behind an FWFT FIFO.
// Optional macro WB_PACKER_BEAT_CNT_EN adds a per-job handshaked beat counter.
module wb_out_packer
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int PACK         = DEFAULT_PACK,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int STALL_MARGIN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       stall,
    output logic [DATA_WIDTH*PACK-1:0] m_tdata,
    output logic [PACK-1:0]            m_tkeep,
    output logic                       m_tlast,
    output logic                       m_tvalid,
    input  logic                       m_tready,
`ifdef WB_PACKER_BEAT_CNT_EN
    output logic [15:0]                beat_cnt,
`endif
    output logic                       job_done
);
    localparam int CNT_W    = lane_cnt_w(PACK);
    localparam int FCNT_W   = fifo_ptr_w(FIFO_DEPTH) + 1;
    localparam int BEAT_W   = DATA_WIDTH * PACK;
    localparam int ENTRY_W  = BEAT_W + PACK + 1;
    localparam int STALL_AT = FIFO_DEPTH - STALL_MARGIN;

    typedef logic [PACK-1:0][DATA_WIDTH-1:0] lanes_t;

    wb_state_e        state_q, state_d;
    lanes_t           lanes_q, lanes_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stall_q, stall_d;
    logic             job_done_q, job_done_d;

    logic             push_valid, push_last, empty_job;
    lanes_t           push_data;
    logic [PACK-1:0]  push_keep;

    logic               fifo_empty, fifo_full, fifo_last;
    logic [FCNT_W-1:0]  fifo_count;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic [PACK-1:0]    fifo_keep;
    logic [BEAT_W-1:0]  fifo_data;
    logic               beat_hs, tlast_hs;

    function automatic logic [PACK-1:0] keep_for(input logic [CNT_W-1:0] n);
        logic [PACK-1:0] k;
        for (int i = 0; i < PACK; i++) k[i] = (CNT_W'(i) < n);
        return k;
    endfunction

    assign {fifo_last, fifo_keep, fifo_data} = fifo_rdata;
    assign beat_hs  = m_tvalid && m_tready;
    assign tlast_hs = beat_hs && fifo_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            lanes_q    <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            job_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lanes_q    <= lanes_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
            job_done_q <= job_done_d;
        end
    end

    // A full register is held back until the job's next event, so tlast always rides real data.
    always_comb begin
        state_d    = state_q;
        lanes_d    = lanes_q;
        count_d    = count_q;
        push_valid = 1'b0;
        push_data  = lanes_q;
        push_keep  = '1;
        push_last  = 1'b0;
        empty_job  = 1'b0;
        case (state_q)
            RUN: begin
                if (in_valid && count_q == CNT_W'(PACK)) begin
                    push_valid = 1'b1;
                    lanes_d[0] = in_data;
                    count_d    = CNT_W'(1);
                    if (in_last) state_d = FLUSH2;
                end else if (in_valid) begin
                    for (int i = 0; i < PACK; i++)
                        if (CNT_W'(i) == count_q) lanes_d[i] = in_data;
                    count_d = count_q + CNT_W'(1);
                    if (in_last) begin
                        push_valid = 1'b1;
                        push_data  = lanes_d;
                        push_keep  = keep_for(count_q + CNT_W'(1));
                        push_last  = 1'b1;
                        count_d    = '0;
                        state_d    = DRAIN;
                    end
                end else if (in_last) begin
                    if (count_q != '0) begin
                        push_valid = 1'b1;
                        push_keep  = keep_for(count_q);
                        push_last  = 1'b1;
                        count_d    = '0;
                        state_d    = DRAIN;
                    end else begin
                        empty_job = 1'b1;
                    end
                end
            end
            FLUSH2: begin
                push_valid = 1'b1;
                push_keep  = keep_for(count_q);
                push_last  = 1'b1;
                count_d    = '0;
                state_d    = DRAIN;
            end
            DRAIN: begin
                if (tlast_hs) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_d = (int'(fifo_count) + int'(push_valid) >= STALL_AT) || fifo_full
                  || (state_d != RUN);
        job_done_d = tlast_hs || empty_job;
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q != RUN) assert (!in_valid);
    end

    wb_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_valid),
        .push_data ({push_last, push_keep, push_data}),
        .pop       (beat_hs),
        .pop_data  (fifo_rdata),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Payload is gated with valid so idle outputs read as zero.
    assign m_tvalid = !fifo_empty;
    assign m_tdata  = m_tvalid ? fifo_data : '0;
    assign m_tkeep  = m_tvalid ? fifo_keep : '0;
    assign m_tlast  = m_tvalid && fifo_last;
    assign stall    = stall_q;
    assign job_done = job_done_q;

`ifdef WB_PACKER_BEAT_CNT_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (job_done_q) beat_cnt_d = '0;
        if (beat_hs && beat_cnt_d != 16'hFFFF) beat_cnt_d = beat_cnt_d + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) beat_cnt_q <= '0;
        else     beat_cnt_q <= beat_cnt_d;
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_wb_out_packer.sv
// Scoreboard bench for wb_out_packer: a job-level chunking model predicts beats,
// a negedge monitor compares every handshaked beat. Covers WB_PACKER_BEAT_CNT_EN.
module tb_wb_out_packer;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   keep;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         stall;
    logic [127:0] m_tdata;
    logic [3:0]   m_tkeep;
    logic         m_tlast;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic         job_done;
`ifdef WB_PACKER_BEAT_CNT_EN
    logic [15:0]  beat_cnt;
`endif

    wb_out_packer dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .stall    (stall),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
`ifdef WB_PACKER_BEAT_CNT_EN
        .beat_cnt (beat_cnt),
`endif
        .job_done (job_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_hs_cyc = -100;
    int in_last_cyc = -100;
    int last_word_cyc = -100;
    int sent_cnt = 0;
    int beat_idx = 0;
    bit rand_ready = 1'b0;

    beat_t       exp_q[$];
    logic [31:0] job_words[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Reference: a job of n words is ceil(n/PACK) beats, first word in lane 0, tlast on the final chunk.
    function automatic int expect_job();
        int n = job_words.size();
        int beats = 0;
        for (int b = 0; b * 4 < n; b++) begin
            beat_t e;
            e.data = '0;
            e.keep = '0;
            for (int l = 0; l < 4; l++) begin
                if (b * 4 + l < n) begin
                    e.data[l*32 +: 32] = job_words[b*4 + l];
                    e.keep[l] = 1'b1;
                end
            end
            e.last = ((b + 1) * 4 >= n);
            exp_q.push_back(e);
            beats++;
        end
        return beats;
    endfunction

    // Monitor: compare every handshaked beat against the scoreboard head.
    always @(negedge clk) begin : monitor
        beat_t e;
        bit ok;
        if (!rst && m_tvalid && m_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got data=%h keep=%h last=%b, expected no beat",
                         m_tdata, m_tkeep, m_tlast);
            end else begin
                e = exp_q.pop_front();
                ok = (m_tkeep === e.keep) && (m_tlast === e.last);
                for (int l = 0; l < 4; l++)
                    if (e.keep[l] && m_tdata[l*32 +: 32] !== e.data[l*32 +: 32]) ok = 1'b0;
                if (!ok) begin
                    errors++;
                    $display("FAIL beat%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                             beat_idx, m_tdata, m_tkeep, m_tlast, e.data, e.keep, e.last);
                end
            end
            beat_idx++;
            if (m_tlast) last_hs_cyc = cyc;
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) m_tready = ($urandom_range(0, 3) != 0);
        end
    end

    // Writeback model: never presents a word while stall is high.
    task automatic drive(input logic [31:0] w, input bit v, input bit l);
        int g = 0;
        if (v) begin
            while (stall === 1'b1 && g < 1000) begin
                @(posedge clk);
                #1;
                g++;
            end
            if (g >= 1000) begin
                checks++;
                errors++;
                $display("FAIL stall_wait: stall still %b after %0d cycles, expected 0", stall, g);
            end
        end
        in_data  = w;
        in_valid = v;
        in_last  = l;
        if (l) in_last_cyc = cyc;
        if (v) last_word_cyc = cyc;
        @(posedge clk);
        #1;
        if (v) sent_cnt++;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_job(input int gap, input bit same);
        int n = job_words.size();
        if (n == 0) begin
            drive('0, 1'b0, 1'b1);
            return;
        end
        for (int i = 0; i < n - 1; i++) drive(job_words[i], 1'b1, 1'b0);
        if (same) begin
            drive(job_words[n-1], 1'b1, 1'b1);
        end else begin
            drive(job_words[n-1], 1'b1, 1'b0);
            repeat (gap - 1) begin
                @(posedge clk);
                #1;
            end
            drive('0, 1'b0, 1'b1);
        end
    endtask

    // stall_mode: 0 ignore, 1 stall must stay high until job_done, 2 stall must stay low.
    task automatic wait_job_done(input int exp_beats, input bit empty, input int stall_mode,
                                 input string tag);
        int g = 0;
        int bad = 0;
        @(negedge clk);
        while (job_done !== 1'b1 && g < 3000) begin
            if (stall_mode == 1 && stall !== 1'b1) bad++;
            if (stall_mode == 2 && stall !== 1'b0) bad++;
            @(negedge clk);
            g++;
        end
        if (g >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s_job_done_timeout: job_done still %b after %0d cycles, expected 1",
                     tag, job_done, g);
        end else begin
            if (empty) check({tag, "_jd_cycle"}, cyc, in_last_cyc + 1);
            else       check({tag, "_jd_cycle"}, cyc, last_hs_cyc + 1);
            if (stall_mode == 2 && stall !== 1'b0) bad++;
            if (stall_mode != 0) check({tag, "_stall"}, bad, 0);
            check({tag, "_drained"}, exp_q.size(), 0);
`ifdef WB_PACKER_BEAT_CNT_EN
            check({tag, "_beat_cnt"}, beat_cnt, exp_beats);
`else
            if (exp_beats < 0) check({tag, "_beats"}, exp_beats, 0);
`endif
            @(negedge clk);
            check({tag, "_jd_pulse"}, job_done, 0);
`ifdef WB_PACKER_BEAT_CNT_EN
            check({tag, "_beat_cnt_clr"}, beat_cnt, 0);
`endif
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int nb;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", m_tvalid, 0);
        check("rst_stall", stall, 0);
        check("rst_job_done", job_done, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tkeep", m_tkeep, 0);
        check("rst_tlast", m_tlast, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two full beats, in_last two cycles after the final word.
        job_words = {};
        for (int i = 1; i <= 8; i++) job_words.push_back(32'(i));
        nb = expect_job();
        send_job(2, 1'b0);
        wait_job_done(nb, 1'b0, 0, "t1");
        check("t1_latency_ge2", (last_hs_cyc - last_word_cyc) >= 2, 1);

        // Partial final beat.
        job_words = {};
        for (int i = 0; i < 6; i++) job_words.push_back(32'hA0 + 32'(i));
        nb = expect_job();
        send_job(1, 1'b0);
        wait_job_done(nb, 1'b0, 0, "t2");

        // Word 9 with in_last while the register is full: FLUSH2 path.
        job_words = {};
        for (int i = 1; i <= 9; i++) job_words.push_back(32'(i));
        nb = expect_job();
        send_job(1, 1'b1);
        wait_job_done(nb, 1'b0, 1, "t3");

        // Backpressure: 64 random words with the sink stalled at first.
        m_tready = 1'b0;
        job_words = {};
        for (int i = 0; i < 64; i++) job_words.push_back($urandom);
        nb = expect_job();
        sent_cnt = 0;
        fork
            send_job(1, 1'b0);
            begin : observer
                int g = 0;
                @(negedge clk);
                while (stall !== 1'b1 && g < 500) begin
                    @(negedge clk);
                    g++;
                end
                check("t4_stall_rise_words", sent_cnt, 49);
                check("t4_tvalid_held", m_tvalid, 1);
                repeat (5) @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        wait_job_done(nb, 1'b0, 0, "t4");

        // Empty job.
        job_words = {};
        nb = expect_job();
        send_job(1, 1'b0);
        wait_job_done(nb, 1'b1, 2, "t5");

        // Randomized jobs under random sink backpressure.
        rand_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            int n = $urandom_range(0, 13);
            bit same = (n > 0) && ($urandom_range(0, 1) == 1);
            int gap = $urandom_range(1, 3);
            job_words = {};
            for (int i = 0; i < n; i++) job_words.push_back($urandom);
            nb = expect_job();
            send_job(gap, same);
            wait_job_done(nb, n == 0, (n == 0) ? 2 : 0, "rnd");
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #3;

        // Reset mid-job with three beats queued.
        m_tready = 1'b0;
        for (int i = 0; i < 13; i++) drive(32'h100 + 32'(i), 1'b1, 1'b0);
        check("t6_pre_rst_tvalid", m_tvalid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("t6_rst_tvalid", m_tvalid, 0);
        check("t6_rst_stall", stall, 0);
        m_tready = 1'b1;
        job_words = {};
        for (int i = 0; i < 4; i++) job_words.push_back(32'h200 + 32'(i));
        nb = expect_job();
        send_job(1, 1'b0);
        wait_job_done(nb, 1'b0, 0, "t6");

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
